// File: rtl/ahb_pkg.sv
// AHB-Lite encodings shared by the burst master and the SRAM slave interface.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'd0;
   localparam logic [2:0] HBURST_INCR   = 3'd1;
   localparam logic [2:0] HBURST_WRAP4  = 3'd2;
   localparam logic [2:0] HBURST_INCR4  = 3'd3;
   localparam logic [2:0] HBURST_WRAP8  = 3'd4;
   localparam logic [2:0] HBURST_INCR8  = 3'd5;
   localparam logic [2:0] HBURST_WRAP16 = 3'd6;
   localparam logic [2:0] HBURST_INCR16 = 3'd7;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HW   = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   localparam int unsigned BEAT_W = 5;

   typedef enum logic [1:0] {
      MST_IDLE,
      MST_ADDR,
      MST_LAST,
      MST_ERR
   } mst_state_t;

   // Beat count of a burst; undefined-length INCR takes len, with 0 meaning 1.
   function automatic logic [BEAT_W-1:0] beats_of(input logic [2:0] hburst,
                                                  input logic [BEAT_W-1:0] len);
      case (hburst)
         HBURST_INCR:                  beats_of = (len == '0) ? BEAT_W'(1) : len;
         HBURST_WRAP4,  HBURST_INCR4:  beats_of = BEAT_W'(4);
         HBURST_WRAP8,  HBURST_INCR8:  beats_of = BEAT_W'(8);
         HBURST_WRAP16, HBURST_INCR16: beats_of = BEAT_W'(16);
         default:                      beats_of = BEAT_W'(1);
      endcase
   endfunction

   function automatic logic is_wrap(input logic [2:0] hburst);
      return (hburst == HBURST_WRAP4) || (hburst == HBURST_WRAP8) ||
             (hburst == HBURST_WRAP16);
   endfunction

endpackage

// File: rtl/ahb_addr_gen.sv
// Next beat address for INCR/WRAP bursts and 1KB boundary crossing detect.
module ahb_addr_gen
   import ahb_pkg::*;
#(
   parameter int unsigned AW = 32
) (
   input  logic [AW-1:0]     addr,
   input  logic [2:0]        size,
   input  logic [2:0]        burst,
   input  logic [BEAT_W-1:0] beats,
   output logic [AW-1:0]     next_addr_c,
   output logic              cross_1k_c
);

   logic [AW-1:0] inc;
   logic [AW-1:0] incr_addr;
   logic [AW-1:0] wrap_mask;

   always_comb begin
      inc         = AW'(1) << size;
      incr_addr   = addr + inc;
      wrap_mask   = (AW'(beats) << size) - AW'(1);
      next_addr_c = incr_addr;
      if (is_wrap(burst)) begin
         next_addr_c = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      end
      // Wrapping bursts stay inside an aligned window, so only INCR types can cross.
      cross_1k_c  = !is_wrap(burst) && (next_addr_c[AW-1:10] != addr[AW-1:10]);
   end

endmodule

// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: turns one command into a pipelined address/data burst.
module ahb_burst_master
   import ahb_pkg::*;
#(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) (
   input  logic          hclk,
   input  logic          hreset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [AW-1:0] cmd_addr,
   input  logic          cmd_write,
   input  logic [2:0]    cmd_size,
   input  logic [2:0]    cmd_burst,
   input  logic [4:0]    cmd_len,
   input  logic [DW-1:0] wdata,
   output logic          wdata_req,
   output logic [DW-1:0] rdata,
   output logic          rdata_valid,
   output logic          done,
   output logic          err,
   output logic          busy,
   output logic [AW-1:0] haddr,
   output logic [1:0]    htrans,
   output logic          hwrite,
   output logic [2:0]    hsize,
   output logic [2:0]    hburst,
   output logic [DW-1:0] hwdata,
   input  logic          hready,
   input  logic [1:0]    hresp,
   input  logic [DW-1:0] hrdata
);

   mst_state_t        state_q, state_d;
   logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [BEAT_W-1:0] beats_q, beats_d;
   logic              dp_valid_q, dp_valid_d;
   logic              dp_write_q, dp_write_d;
   logic [AW-1:0]     haddr_d;
   logic [1:0]        htrans_d;
   logic              hwrite_d;
   logic [2:0]        hsize_d;
   logic [2:0]        hburst_d;
   logic [DW-1:0]     hwdata_d;
   logic              cmd_ready_d, done_d, err_d, busy_d;
   logic              ahb_err_c;
   logic [AW-1:0]     next_addr_c;
   logic              cross_1k_c;

   ahb_addr_gen #(.AW(AW)) u_addr_gen (
      .addr        (haddr),
      .size        (hsize),
      .burst       (hburst),
      .beats       (beats_q),
      .next_addr_c (next_addr_c),
      .cross_1k_c  (cross_1k_c)
   );

   assign rdata       = hrdata;
   assign rdata_valid = dp_valid_q && !dp_write_q && hready;
   // First cycle of a two-cycle ERROR response on the pending data phase.
   assign ahb_err_c   = dp_valid_q && (hresp == HRESP_ERROR) && !hready;

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      beats_d    = beats_q;
      dp_valid_d = dp_valid_q;
      dp_write_d = dp_write_q;
      haddr_d    = haddr;
      htrans_d   = htrans;
      hwrite_d   = hwrite;
      hsize_d    = hsize;
      hburst_d   = hburst;
      hwdata_d   = hwdata;
      done_d     = 1'b0;
      err_d      = 1'b0;
      wdata_req  = 1'b0;

      case (state_q)
         MST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               if (cmd_size > HSIZE_WORD) begin
                  err_d = 1'b1;
               end else begin
                  state_d    = MST_ADDR;
                  beats_d    = beats_of(cmd_burst, cmd_len);
                  beat_cnt_d = beats_of(cmd_burst, cmd_len);
                  haddr_d    = cmd_addr & ~((AW'(1) << cmd_size) - AW'(1));
                  htrans_d   = HTRANS_NONSEQ;
                  hwrite_d   = cmd_write;
                  hsize_d    = cmd_size;
                  hburst_d   = cmd_burst;
               end
            end
         end
         MST_ADDR: begin
            if (ahb_err_c) begin
               htrans_d   = HTRANS_IDLE;
               dp_valid_d = 1'b0;
               state_d    = MST_ERR;
            end else if (hready) begin
               dp_valid_d = 1'b1;
               dp_write_d = hwrite;
               beat_cnt_d = beat_cnt_q - BEAT_W'(1);
               if (hwrite) begin
                  wdata_req = 1'b1;
                  hwdata_d  = wdata;
               end
               if (beat_cnt_q == BEAT_W'(1)) begin
                  htrans_d = HTRANS_IDLE;
                  state_d  = MST_LAST;
               end else begin
                  haddr_d  = next_addr_c;
                  htrans_d = cross_1k_c ? HTRANS_NONSEQ : HTRANS_SEQ;
               end
            end
         end
         MST_LAST: begin
            if (ahb_err_c) begin
               dp_valid_d = 1'b0;
               state_d    = MST_ERR;
            end else if (hready) begin
               dp_valid_d = 1'b0;
               done_d     = 1'b1;
               state_d    = MST_IDLE;
            end
         end
         MST_ERR: begin
            if (hready) begin
               err_d   = 1'b1;
               state_d = MST_IDLE;
            end
         end
         default: state_d = MST_IDLE;
      endcase

      // Ready only once idle for a full cycle, leaving a bubble after each burst.
      cmd_ready_d = (state_q == MST_IDLE) && (state_d == MST_IDLE);
      busy_d      = (state_d != MST_IDLE);
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_q    <= MST_IDLE;
         beat_cnt_q <= '0;
         beats_q    <= '0;
         dp_valid_q <= 1'b0;
         dp_write_q <= 1'b0;
         haddr      <= '0;
         htrans     <= HTRANS_IDLE;
         hwrite     <= 1'b0;
         hsize      <= '0;
         hburst     <= '0;
         hwdata     <= '0;
         cmd_ready  <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         beats_q    <= beats_d;
         dp_valid_q <= dp_valid_d;
         dp_write_q <= dp_write_d;
         haddr      <= haddr_d;
         htrans     <= htrans_d;
         hwrite     <= hwrite_d;
         hsize      <= hsize_d;
         hburst     <= hburst_d;
         hwdata     <= hwdata_d;
         cmd_ready  <= cmd_ready_d;
         done       <= done_d;
         err        <= err_d;
         busy       <= busy_d;
      end
   end

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master with a scripted AHB slave response.
module tb_ahb_burst_master;
   import ahb_pkg::*;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int NO_EV = 100;

   logic          hclk = 1'b0;
   logic          hreset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr;
   logic          cmd_write;
   logic [2:0]    cmd_size;
   logic [2:0]    cmd_burst;
   logic [4:0]    cmd_len;
   logic [DW-1:0] wdata;
   logic          wdata_req;
   logic [DW-1:0] rdata;
   logic          rdata_valid;
   logic          done;
   logic          err;
   logic          busy;
   logic [AW-1:0] haddr;
   logic [1:0]    htrans;
   logic          hwrite;
   logic [2:0]    hsize;
   logic [2:0]    hburst;
   logic [DW-1:0] hwdata;
   logic          hready;
   logic [1:0]    hresp;
   logic [DW-1:0] hrdata;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] got_addr[$];
   logic [1:0]  got_trans[$];
   logic [31:0] exp_addr[$];
   logic [1:0]  exp_trans[$];
   int n_wreq, n_rvalid, n_active, n_busy_tr, fin_cyc, saw_done, saw_err;

   always #5 hclk = ~hclk;

   ahb_burst_master #(.AW(AW), .DW(DW)) dut (
      .hclk        (hclk),
      .hreset      (hreset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_addr    (cmd_addr),
      .cmd_write   (cmd_write),
      .cmd_size    (cmd_size),
      .cmd_burst   (cmd_burst),
      .cmd_len     (cmd_len),
      .wdata       (wdata),
      .wdata_req   (wdata_req),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .done        (done),
      .err         (err),
      .busy        (busy),
      .haddr       (haddr),
      .htrans      (htrans),
      .hwrite      (hwrite),
      .hsize       (hsize),
      .hburst      (hburst),
      .hwdata      (hwdata),
      .hready      (hready),
      .hresp       (hresp),
      .hrdata      (hrdata)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h exp=%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic ex(input logic [31:0] a, input logic [1:0] t);
      exp_addr.push_back(a);
      exp_trans.push_back(t);
   endtask

   task automatic cmp_addrs(input string tag);
      check({tag, "_nbeats"}, 32'(got_addr.size()), 32'(exp_addr.size()));
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
         check($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
         check($sformatf("%s_trans%0d", tag, i), 32'(got_trans[i]), 32'(exp_trans[i]));
      end
      exp_addr.delete();
      exp_trans.delete();
   endtask

   task automatic wait_ready();
      int w = 0;
      while (!cmd_ready && w < 8) begin
         tick();
         w++;
      end
      check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
   endtask

   // Issues one command, then plays the slave cycle by cycle until done or err.
   task automatic run_cmd(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                          input logic [2:0] burst, input logic [4:0] len,
                          input int stall_at, input int stall_len, input int err_at);
      logic        have_wd = 1'b0;
      logic [31:0] exp_hwdata = '0;
      logic        prev_hold = 1'b0;
      logic [31:0] prev_addr = '0;
      logic [1:0]  prev_trans = '0;
      got_addr.delete();
      got_trans.delete();
      n_wreq = 0; n_rvalid = 0; n_active = 0; n_busy_tr = 0;
      fin_cyc = -1; saw_done = 0; saw_err = 0;
      wait_ready();
      cmd_valid = 1'b1; cmd_addr = addr; cmd_write = wr;
      cmd_size = size; cmd_burst = burst; cmd_len = len;
      tick();
      cmd_valid = 1'b0;
      for (int c = 0; c < 40; c++) begin
         hready = !((c >= stall_at && c < stall_at + stall_len) || c == err_at);
         hresp  = (c == err_at || c == err_at + 1) ? HRESP_ERROR : HRESP_OKAY;
         hrdata = 32'hD000_0000 | 32'(c);
         wdata  = 32'hC000_0000 | 32'(c);
         #1;
         if (have_wd) begin
            check("hwdata", hwdata, exp_hwdata);
            have_wd = 1'b0;
         end
         if (prev_hold) begin
            check("hold_addr", haddr, prev_addr);
            check("hold_trans", 32'(htrans), 32'(prev_trans));
         end
         if (c == err_at + 1) check("err_htrans_idle", 32'(htrans), 32'(HTRANS_IDLE));
         if (htrans[1] && hready) begin
            got_addr.push_back(haddr);
            got_trans.push_back(htrans);
         end
         if (htrans != HTRANS_IDLE) n_active++;
         if (htrans == HTRANS_BUSY) n_busy_tr++;
         if (wdata_req) begin
            n_wreq++;
            exp_hwdata = wdata;
            have_wd = 1'b1;
         end
         if (rdata_valid) begin
            n_rvalid++;
            check("rdata", rdata, hrdata);
         end
         prev_hold  = (htrans != HTRANS_IDLE) && !hready && (hresp == HRESP_OKAY);
         prev_addr  = haddr;
         prev_trans = htrans;
         if (done) saw_done++;
         if (err) saw_err++;
         if (done || err) begin
            fin_cyc = c;
            break;
         end
         tick();
      end
      if (fin_cyc < 0) check("timeout", 32'd0, 32'd1);
      hready = 1'b1;
      hresp  = HRESP_OKAY;
      tick();
      check("pulse_done_clear", 32'(done), 32'd0);
      check("pulse_err_clear", 32'(err), 32'd0);
   endtask

   task automatic expect_run(input string tag, input int wreq, input int rvalid,
                             input int dn, input int er, input int cyc);
      check({tag, "_wreq"}, 32'(n_wreq), 32'(wreq));
      check({tag, "_rvalid"}, 32'(n_rvalid), 32'(rvalid));
      check({tag, "_done"}, 32'(saw_done), 32'(dn));
      check({tag, "_err"}, 32'(saw_err), 32'(er));
      check({tag, "_cyc"}, 32'(fin_cyc), 32'(cyc));
      check({tag, "_no_busy_tr"}, 32'(n_busy_tr), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      hreset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0;
      cmd_size = '0; cmd_burst = '0; cmd_len = '0; wdata = '0;
      hready = 1'b1; hresp = HRESP_OKAY; hrdata = '0;
      repeat (3) tick();
      #1;
      check("rst_htrans", 32'(htrans), 32'(HTRANS_IDLE));
      check("rst_haddr", haddr, 32'd0);
      check("rst_hwdata", hwdata, 32'd0);
      check("rst_hwrite", 32'(hwrite), 32'd0);
      check("rst_hsize", 32'(hsize), 32'd0);
      check("rst_hburst", 32'(hburst), 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      hreset = 1'b0;
      tick();

      // WORD write SINGLE, unaligned start forced down to 0x10
      run_cmd(32'h13, 1'b1, HSIZE_WORD, HBURST_SINGLE, 5'd0, NO_EV, 0, NO_EV);
      ex(32'h10, HTRANS_NONSEQ);
      cmp_addrs("single");
      expect_run("single", 1, 0, 1, 0, 2);

      // WRAP4 WORD read wrapping at the 16-byte window
      run_cmd(32'h38, 1'b0, HSIZE_WORD, HBURST_WRAP4, 5'd0, NO_EV, 0, NO_EV);
      ex(32'h38, HTRANS_NONSEQ); ex(32'h3C, HTRANS_SEQ);
      ex(32'h30, HTRANS_SEQ);    ex(32'h34, HTRANS_SEQ);
      cmp_addrs("wrap4");
      expect_run("wrap4", 0, 4, 1, 0, 5);

      // INCR len=3 HW write across the 1KB boundary
      run_cmd(32'h3FE, 1'b1, HSIZE_HW, HBURST_INCR, 5'd3, NO_EV, 0, NO_EV);
      ex(32'h3FE, HTRANS_NONSEQ); ex(32'h400, HTRANS_NONSEQ); ex(32'h402, HTRANS_SEQ);
      cmp_addrs("incr3");
      expect_run("incr3", 3, 0, 1, 0, 4);

      // INCR8 BYTE read, hready low for two cycles during beat 3
      run_cmd(32'h1FD, 1'b0, HSIZE_BYTE, HBURST_INCR8, 5'd0, 2, 2, NO_EV);
      for (int i = 0; i < 8; i++) ex(32'h1FD + 32'(i), (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ);
      cmp_addrs("incr8");
      expect_run("incr8", 0, 8, 1, 0, 11);

      // ERROR response on beat 2 of an INCR4 write
      run_cmd(32'h200, 1'b1, HSIZE_WORD, HBURST_INCR4, 5'd0, NO_EV, 0, 2);
      ex(32'h200, HTRANS_NONSEQ); ex(32'h204, HTRANS_SEQ);
      cmp_addrs("error");
      expect_run("error", 2, 0, 0, 1, 4);
      check("error_ready_back", 32'(cmd_ready), 32'd1);

      // INCR with len 0 behaves as a single beat
      run_cmd(32'h40, 1'b0, HSIZE_WORD, HBURST_INCR, 5'd0, NO_EV, 0, NO_EV);
      ex(32'h40, HTRANS_NONSEQ);
      cmp_addrs("len0");
      expect_run("len0", 0, 1, 1, 0, 2);

      // Oversized hsize is rejected without bus activity
      run_cmd(32'h80, 1'b0, 3'b011, HBURST_SINGLE, 5'd0, NO_EV, 0, NO_EV);
      cmp_addrs("badsize");
      expect_run("badsize", 0, 0, 0, 1, 0);
      check("badsize_active", 32'(n_active), 32'd0);

      // Reset in the middle of an INCR16 read
      wait_ready();
      cmd_valid = 1'b1; cmd_addr = 32'h0; cmd_write = 1'b0;
      cmd_size = HSIZE_WORD; cmd_burst = HBURST_INCR16; cmd_len = 5'd0;
      tick();
      cmd_valid = 1'b0;
      repeat (3) tick();
      #1;
      check("rstmid_before", 32'(htrans), 32'(HTRANS_SEQ));
      check("rstmid_busy_before", 32'(busy), 32'd1);
      hreset = 1'b1;
      tick();
      #1;
      check("rstmid_htrans", 32'(htrans), 32'(HTRANS_IDLE));
      check("rstmid_haddr", haddr, 32'd0);
      check("rstmid_busy", 32'(busy), 32'd0);
      check("rstmid_ready", 32'(cmd_ready), 32'd1);
      hreset = 1'b0;
      tick();
      #1;
      check("rstmid_after_htrans", 32'(htrans), 32'(HTRANS_IDLE));
      check("rstmid_after_done", 32'(done), 32'd0);
      check("rstmid_after_err", 32'(err), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
